// File: rtl/multiplier_sequential_param.sv
// Iterative shift-add multiplier: retires BITS_PER_CYCLE multiplier bits per clock and
// produces a registered 2*WIDTH-bit product, unsigned or two's complement.
module multiplier_sequential_param #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Start_In,
    input  logic                 Signed_In,
    input  logic                 Abort_In,
    input  logic [WIDTH-1:0]     Data_A_In,
    input  logic [WIDTH-1:0]     Data_B_In,
    output logic                 Ready_Out,
    output logic                 Done_Out,
    output logic [2*WIDTH-1:0]   Multiplied_Result_Out
);

    localparam int unsigned ITER  = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(ITER + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    result_q, result_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] a_abs, b_abs;
    logic [PW-1:0]    partial;

    // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
    always_comb begin
        a_abs = (Signed_In && Data_A_In[WIDTH-1]) ? -Data_A_In : Data_A_In;
        b_abs = (Signed_In && Data_B_In[WIDTH-1]) ? -Data_B_In : Data_B_In;
    end

    // a_q is pre-shifted to the weight of the current multiplier digit.
    always_comb begin
        partial = '0;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            if (b_q[i]) begin
                partial = partial + (a_q << i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (Start_In) begin
                    a_d     = {{WIDTH{1'b0}}, a_abs};
                    b_d     = b_abs;
                    neg_d   = Signed_In & (Data_A_In[WIDTH-1] ^ Data_B_In[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (Abort_In) begin
                    state_d = StIdle;
                end else begin
                    acc_d = acc_q + partial;
                    a_d   = a_q << BITS_PER_CYCLE;
                    b_d   = b_q >> BITS_PER_CYCLE;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = StFinish;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
                if (!Abort_In) begin
                    // Negating a zero accumulator yields zero, so no negative zero appears.
                    result_d = neg_q ? -acc_q : acc_q;
                    done_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign Ready_Out             = (state_q == StIdle);
    assign Done_Out              = done_q;
    assign Multiplied_Result_Out = result_q;

endmodule

// File: tb/tb_multiplier_sequential_param.sv
// Directed bench for the sequential multiplier: a 32-bit, 1-bit-per-cycle instance and a
// 16-bit, 4-bits-per-cycle instance, checked against hand-computed products and latencies.
module tb_multiplier_sequential_param;

    logic        Clk;
    logic        rst_n;
    logic        start, sgn, abort;
    logic [31:0] a, b;
    logic        ready, done;
    logic [63:0] res;

    logic        start2, sgn2, abort2;
    logic [15:0] a2, b2;
    logic        ready2, done2;
    logic [31:0] res2;

    int n_cmp;
    int n_err;

    multiplier_sequential_param #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .Clk                   (Clk),
        .Reset_n               (rst_n),
        .Start_In              (start),
        .Signed_In             (sgn),
        .Abort_In              (abort),
        .Data_A_In             (a),
        .Data_B_In             (b),
        .Ready_Out             (ready),
        .Done_Out              (done),
        .Multiplied_Result_Out (res)
    );

    multiplier_sequential_param #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut4 (
        .Clk                   (Clk),
        .Reset_n               (rst_n),
        .Start_In              (start2),
        .Signed_In             (sgn2),
        .Abort_In              (abort2),
        .Data_A_In             (a2),
        .Data_B_In             (b2),
        .Ready_Out             (ready2),
        .Done_Out              (done2),
        .Multiplied_Result_Out (res2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One 32x32 operation; operands and mode are scrambled right after accept.
    task automatic run32(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                         input logic is, input logic [63:0] exp);
        int k;
        bit seen, busy_ok;
        a = ia; b = ib; sgn = is; start = 1'b1;
        tick();
        start = 1'b0; a = ~ia; b = ~ib; sgn = ~is;
        k = 0; seen = 0; busy_ok = 1;
        while (!seen && k < 40) begin
            tick();
            k++;
            if (done) seen = 1;
            else if (ready) busy_ok = 0;
        end
        check_val({tag, "_lat"}, 64'(k), 64'd33);
        check_val({tag, "_busy"}, 64'(busy_ok), 64'd1);
        check_val({tag, "_res"}, res, exp);
        check_val({tag, "_rdy"}, 64'(ready), 64'd1);
        tick();
        check_val({tag, "_done_clr"}, 64'(done), 64'd0);
    endtask

    task automatic run16(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                         input logic is, input logic [31:0] exp);
        int k;
        bit seen;
        a2 = ia; b2 = ib; sgn2 = is; start2 = 1'b1;
        tick();
        start2 = 1'b0; a2 = ~ia; b2 = ~ib; sgn2 = ~is;
        k = 0; seen = 0;
        while (!seen && k < 20) begin
            tick();
            k++;
            if (done2) seen = 1;
        end
        check_val({tag, "_lat"}, 64'(k), 64'd5);
        check_val({tag, "_res"}, 64'(res2), 64'(exp));
        tick();
        check_val({tag, "_done_clr"}, 64'(done2), 64'd0);
    endtask

    initial begin
        int n_done, e, j;
        bit prev_done, dbl;
        logic [63:0] b2b_res [3];
        int          b2b_edge [3];
        logic [31:0] b2b_a [3];
        logic [31:0] b2b_b [3];

        n_cmp = 0; n_err = 0;
        rst_n = 1'b0;
        start = 0; sgn = 0; abort = 0; a = '0; b = '0;
        start2 = 0; sgn2 = 0; abort2 = 0; a2 = '0; b2 = '0;
        #3;
        check_val("rst_ready", 64'(ready), 64'd1);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_res", res, 64'd0);
        #10 rst_n = 1'b1;
        tick();

        run32("u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        run32("s_m3x7", 32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
        run32("s_minsq", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        run32("s_minx1", 32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000);
        run32("u_minx1", 32'h8000_0000, 32'd1, 1'b0, 64'h0000_0000_8000_0000);
        run32("s_zero", 32'd0, 32'hFFFF_FFFB, 1'b1, 64'd0);
        run32("s_m1m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1);
        run32("u_shift", 32'h1234_5678, 32'h10, 1'b0, 64'h0000_0001_2345_6780);

        run16("w16_umax", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
        run16("w16_m1xmin", 16'hFFFF, 16'h8000, 1'b1, 32'h0000_8000);
        run16("w16_m3x7", 16'hFFFD, 16'h0007, 1'b1, 32'hFFFF_FFEB);
        run16("w16_ushift", 16'h1234, 16'h0010, 1'b0, 32'h0001_2340);
        run16("w16_minsq", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000);

        // Start pulsed mid-operation must be ignored.
        a = 32'd6; b = 32'd7; sgn = 0; start = 1;
        tick();
        start = 0;
        repeat (4) tick();
        a = 32'd100; b = 32'd100; start = 1;
        tick();
        start = 0;
        n_done = 0;
        repeat (40) begin
            tick();
            if (done) n_done++;
        end
        check_val("busy_ndone", 64'(n_done), 64'd1);
        check_val("busy_res", res, 64'd42);

        // Abort during CALC.
        a = 32'd3; b = 32'd3; start = 1;
        tick();
        start = 0;
        repeat (10) tick();
        check_val("abort_busy", 64'(ready), 64'd0);
        abort = 1;
        tick();
        abort = 0;
        check_val("abort_ready", 64'(ready), 64'd1);
        n_done = 0;
        repeat (40) begin
            tick();
            if (done) n_done++;
        end
        check_val("abort_ndone", 64'(n_done), 64'd0);
        check_val("abort_res", res, 64'd42);

        // Asynchronous reset mid-operation.
        a = 32'd123; b = 32'd456; start = 1;
        tick();
        start = 0;
        repeat (19) tick();
        rst_n = 0;
        #1;
        check_val("mid_rst_ready", 64'(ready), 64'd1);
        check_val("mid_rst_done", 64'(done), 64'd0);
        check_val("mid_rst_res", res, 64'd0);
        check_val("mid_rst_res16", 64'(res2), 64'd0);
        tick();
        rst_n = 1;
        tick();
        run32("post_rst", 32'd5, 32'd9, 1'b0, 64'd45);

        // Back-to-back with Start held high.
        b2b_a = '{32'd2, 32'd10, 32'h0000_FFFF};
        b2b_b = '{32'd3, 32'd11, 32'h0001_0001};
        b2b_res = '{64'd6, 64'd110, 64'h0000_0000_FFFF_FFFF};
        b2b_edge = '{33, 67, 101};
        a = b2b_a[0]; b = b2b_b[0]; sgn = 0; start = 1;
        tick();
        e = 0; j = 0; prev_done = 0; dbl = 0;
        while (j < 3 && e < 110) begin
            tick();
            e++;
            if (done && prev_done) dbl = 1;
            prev_done = done;
            if (done) begin
                check_val("b2b_res", res, b2b_res[j]);
                check_val("b2b_edge", 64'(e), 64'(b2b_edge[j]));
                j++;
                if (j < 3) begin
                    a = b2b_a[j]; b = b2b_b[j];
                end else begin
                    start = 0;
                end
            end
        end
        start = 0;
        tick();
        if (done && prev_done) dbl = 1;
        check_val("b2b_nops", 64'(j), 64'd3);
        check_val("b2b_double", 64'(dbl), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
